// File: rtl/idex_stage_if.sv
// ID/EX pipeline-register bundle.
//
// Carries the ID-side inputs into the ID/EX stage and the EX-side registered
// outputs plus hazard-unit results back out.
//   IfId_*          : register fields, read data, immediate and control of the
//                     instruction currently in ID
//   Flush_i         : squash the instruction in ID (taken branch / jump)
//   IdEx_*          : registered copies presented to EX / forwarding unit
//   Stall_o         : load-use hazard detected this cycle
//   PcWrite_o,
//   IfIdWrite_o     : upstream write enables (low while stalling)
//   StallCnt_o      : stall-cycle counter (zero unless IDEX_STALL_CNT_EN)
//
// Modports: master = pipeline/bench side, slave = idex_stage.
interface idex_stage_if;
    logic [4:0]  IfId_rs_i;
    logic [4:0]  IfId_rt_i;
    logic [4:0]  IfId_rd_i;
    logic [31:0] RsData_i;
    logic [31:0] RtData_i;
    logic [31:0] Imm_i;
    logic [7:0]  Ctrl_i;
    logic        Flush_i;

    logic [4:0]  IdEx_rs_o;
    logic [4:0]  IdEx_rt_o;
    logic [4:0]  IdEx_rd_o;
    logic [31:0] IdEx_RsData_o;
    logic [31:0] IdEx_RtData_o;
    logic [31:0] IdEx_Imm_o;
    logic [7:0]  IdEx_Ctrl_o;
    logic        IdEx_Valid_o;
    logic        Stall_o;
    logic        PcWrite_o;
    logic        IfIdWrite_o;
    logic [31:0] StallCnt_o;

    modport master (
        output IfId_rs_i, IfId_rt_i, IfId_rd_i, RsData_i, RtData_i, Imm_i,
               Ctrl_i, Flush_i,
        input  IdEx_rs_o, IdEx_rt_o, IdEx_rd_o, IdEx_RsData_o, IdEx_RtData_o,
               IdEx_Imm_o, IdEx_Ctrl_o, IdEx_Valid_o, Stall_o, PcWrite_o,
               IfIdWrite_o, StallCnt_o
    );

    modport slave (
        input  IfId_rs_i, IfId_rt_i, IfId_rd_i, RsData_i, RtData_i, Imm_i,
               Ctrl_i, Flush_i,
        output IdEx_rs_o, IdEx_rt_o, IdEx_rd_o, IdEx_RsData_o, IdEx_RtData_o,
               IdEx_Imm_o, IdEx_Ctrl_o, IdEx_Valid_o, Stall_o, PcWrite_o,
               IfIdWrite_o, StallCnt_o
    );
endinterface

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Ports:
//   clk_i  : pipeline clock, rising edge
//   rst_i  : asynchronous active-low reset, clears every registered output
//   bus    : idex_stage_if.slave (ID-side inputs, EX-side outputs, hazard
//            signals, stall counter)
//
// Ctrl packing: {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}.
//
// Optional feature: define IDEX_STALL_CNT_EN to build a saturating 32-bit
// counter of stalled cycles on StallCnt_o; otherwise StallCnt_o is constant 0.
module idex_stage (
    input  logic         clk_i,
    input  logic         rst_i,
    idex_stage_if.slave  bus
);
    localparam int MEM_READ_BIT = 5;

    logic [4:0]  rs_reg, rt_reg, rd_reg;
    logic [31:0] rs_data_reg, rt_data_reg, imm_reg;
    logic [7:0]  ctrl_reg;
    logic        valid_reg;

    logic        stall;
    logic        bubble;

    // The EX instruction is a load whose destination is read by the ID
    // instruction. A flush overrides the stall so the branch target is
    // fetched; the squashed instruction becomes a bubble anyway.
    always_comb begin
        stall = ctrl_reg[MEM_READ_BIT] & valid_reg & (rt_reg != 5'd0) &
                ((rt_reg == bus.IfId_rs_i) | (rt_reg == bus.IfId_rt_i)) &
                ~bus.Flush_i;
    end

    assign bubble = stall | bus.Flush_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rs_reg      <= '0;
            rt_reg      <= '0;
            rd_reg      <= '0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
            imm_reg     <= '0;
            ctrl_reg    <= '0;
            valid_reg   <= 1'b0;
        end else begin
            // Data fields always follow the inputs; only control and valid
            // are suppressed for a bubble.
            rs_reg      <= bus.IfId_rs_i;
            rt_reg      <= bus.IfId_rt_i;
            rd_reg      <= bus.IfId_rd_i;
            rs_data_reg <= bus.RsData_i;
            rt_data_reg <= bus.RtData_i;
            imm_reg     <= bus.Imm_i;
            ctrl_reg    <= bubble ? 8'd0 : bus.Ctrl_i;
            valid_reg   <= ~bubble;
        end
    end

`ifdef IDEX_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign bus.StallCnt_o = stall_cnt_reg;
`else
    assign bus.StallCnt_o = 32'd0;
`endif

    assign bus.IdEx_rs_o     = rs_reg;
    assign bus.IdEx_rt_o     = rt_reg;
    assign bus.IdEx_rd_o     = rd_reg;
    assign bus.IdEx_RsData_o = rs_data_reg;
    assign bus.IdEx_RtData_o = rt_data_reg;
    assign bus.IdEx_Imm_o    = imm_reg;
    assign bus.IdEx_Ctrl_o   = ctrl_reg;
    assign bus.IdEx_Valid_o  = valid_reg;
    assign bus.Stall_o       = stall;
    assign bus.PcWrite_o     = ~stall;
    assign bus.IfIdWrite_o   = ~stall;
endmodule

// File: tb/tb_idex_stage.sv
// Directed self-checking bench for idex_stage.
module tb_idex_stage;
    localparam logic [7:0] CTRL_LW  = 8'hE8; // RegWrite|MemToReg|MemRead|ALUSrc
    localparam logic [7:0] CTRL_ADD = 8'h86; // RegWrite|RegDst|ALUOp=10

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    idex_stage_if bus();

    idex_stage dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [7:0] ctrl,
                         input logic [31:0] imm, input logic flush);
        bus.IfId_rs_i = rs;
        bus.IfId_rt_i = rt;
        bus.IfId_rd_i = rd;
        bus.Ctrl_i    = ctrl;
        bus.Imm_i     = imm;
        bus.RsData_i  = {27'd0, rs} + 32'h1000;
        bus.RtData_i  = {27'd0, rt} + 32'h2000;
        bus.Flush_i   = flush;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 8'd0, 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (bus.IdEx_Valid_o !== 1'b0 || bus.IdEx_Ctrl_o !== 8'd0 ||
            bus.IdEx_rs_o !== 5'd0 || bus.IdEx_rt_o !== 5'd0 || bus.IdEx_rd_o !== 5'd0 ||
            bus.IdEx_RsData_o !== 32'd0 || bus.IdEx_RtData_o !== 32'd0 ||
            bus.IdEx_Imm_o !== 32'd0 || bus.StallCnt_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_regs valid=%b ctrl=%h rs=%0d rt=%0d imm=%h cnt=%0d required all 0",
                     bus.IdEx_Valid_o, bus.IdEx_Ctrl_o, bus.IdEx_rs_o, bus.IdEx_rt_o,
                     bus.IdEx_Imm_o, bus.StallCnt_o);
        end
        checks++;
        if (bus.Stall_o !== 1'b0 || bus.PcWrite_o !== 1'b1 || bus.IfIdWrite_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_enables stall=%b pcw=%b ifidw=%b required 0/1/1",
                     bus.Stall_o, bus.PcWrite_o, bus.IfIdWrite_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        drive(5'd3, 5'd7, 5'd8, 8'hA5, 32'hFFFF_FFF0, 1'b0);
        step();
        checks++;
        if (bus.IdEx_Ctrl_o !== 8'hA5 || bus.IdEx_Imm_o !== 32'hFFFF_FFF0 ||
            bus.IdEx_Valid_o !== 1'b1) begin
            failures++;
            $display("FAIL pass_ctrl ctrl=%h imm=%h valid=%b required a5/fffffff0/1",
                     bus.IdEx_Ctrl_o, bus.IdEx_Imm_o, bus.IdEx_Valid_o);
        end
        checks++;
        if (bus.IdEx_rs_o !== 5'd3 || bus.IdEx_rt_o !== 5'd7 || bus.IdEx_rd_o !== 5'd8 ||
            bus.IdEx_RsData_o !== 32'h1003 || bus.IdEx_RtData_o !== 32'h2007) begin
            failures++;
            $display("FAIL pass_fields rs=%0d rt=%0d rd=%0d rsd=%h rtd=%h required 3/7/8/1003/2007",
                     bus.IdEx_rs_o, bus.IdEx_rt_o, bus.IdEx_rd_o,
                     bus.IdEx_RsData_o, bus.IdEx_RtData_o);
        end
        // EX now holds a load to $7; an instruction reading $8/$9 is independent.
        @(negedge clk);
        drive(5'd8, 5'd9, 5'd10, 8'h00, 32'd0, 1'b0);
        #1;
        checks++;
        if (bus.Stall_o !== 1'b0) begin
            failures++;
            $display("FAIL pass_nostall stall=%b required 0", bus.Stall_o);
        end
        step();
        $display("test_passthrough done");
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive(5'd1, 5'd2, 5'd0, CTRL_LW, 32'd0, 1'b0);   // lw $2,0($1)
        step();
        @(negedge clk);
        drive(5'd2, 5'd4, 5'd3, CTRL_ADD, 32'd0, 1'b0);  // add $3,$2,$4
        #1;
        checks++;
        if (bus.Stall_o !== 1'b1 || bus.PcWrite_o !== 1'b0 || bus.IfIdWrite_o !== 1'b0) begin
            failures++;
            $display("FAIL lu_stall stall=%b pcw=%b ifidw=%b required 1/0/0",
                     bus.Stall_o, bus.PcWrite_o, bus.IfIdWrite_o);
        end
        step();
        checks++;
        if (bus.IdEx_Ctrl_o !== 8'd0 || bus.IdEx_Valid_o !== 1'b0 || bus.IdEx_rs_o !== 5'd2) begin
            failures++;
            $display("FAIL lu_bubble ctrl=%h valid=%b rs=%0d required 00/0/2",
                     bus.IdEx_Ctrl_o, bus.IdEx_Valid_o, bus.IdEx_rs_o);
        end
        checks++;
        if (bus.Stall_o !== 1'b0 || bus.PcWrite_o !== 1'b1) begin
            failures++;
            $display("FAIL lu_one_cycle stall=%b pcw=%b required 0/1", bus.Stall_o, bus.PcWrite_o);
        end
        step();
        checks++;
        if (bus.IdEx_Ctrl_o !== CTRL_ADD || bus.IdEx_Valid_o !== 1'b1 ||
            bus.IdEx_rs_o !== 5'd2 || bus.IdEx_rd_o !== 5'd3) begin
            failures++;
            $display("FAIL lu_add ctrl=%h valid=%b rs=%0d rd=%0d required 86/1/2/3",
                     bus.IdEx_Ctrl_o, bus.IdEx_Valid_o, bus.IdEx_rs_o, bus.IdEx_rd_o);
        end
        $display("test_load_use done");
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        drive(5'd1, 5'd0, 5'd0, CTRL_LW, 32'd0, 1'b0);   // lw $0,0($1)
        step();
        @(negedge clk);
        drive(5'd0, 5'd4, 5'd3, CTRL_ADD, 32'd0, 1'b0);  // add $3,$0,$4
        #1;
        checks++;
        if (bus.Stall_o !== 1'b0) begin
            failures++;
            $display("FAIL zero_stall stall=%b required 0", bus.Stall_o);
        end
        step();
        checks++;
        if (bus.IdEx_Ctrl_o !== CTRL_ADD || bus.IdEx_Valid_o !== 1'b1) begin
            failures++;
            $display("FAIL zero_nobubble ctrl=%h valid=%b required 86/1",
                     bus.IdEx_Ctrl_o, bus.IdEx_Valid_o);
        end
        $display("test_zero_reg done");
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(5'd1, 5'd2, 5'd0, CTRL_LW, 32'd0, 1'b0);
        step();
        @(negedge clk);
        drive(5'd2, 5'd4, 5'd3, CTRL_ADD, 32'd0, 1'b1);
        #1;
        checks++;
        if (bus.Stall_o !== 1'b0 || bus.PcWrite_o !== 1'b1) begin
            failures++;
            $display("FAIL flush_wins stall=%b pcw=%b required 0/1", bus.Stall_o, bus.PcWrite_o);
        end
        step();
        checks++;
        if (bus.IdEx_Valid_o !== 1'b0 || bus.IdEx_Ctrl_o !== 8'd0) begin
            failures++;
            $display("FAIL flush_bubble valid=%b ctrl=%h required 0/00",
                     bus.IdEx_Valid_o, bus.IdEx_Ctrl_o);
        end
        // Flush alone (no hazard) must also squash.
        @(negedge clk);
        drive(5'd9, 5'd10, 5'd11, CTRL_ADD, 32'd5, 1'b1);
        step();
        checks++;
        if (bus.IdEx_Valid_o !== 1'b0 || bus.IdEx_Ctrl_o !== 8'd0 || bus.IdEx_Imm_o !== 32'd5) begin
            failures++;
            $display("FAIL flush_only valid=%b ctrl=%h imm=%h required 0/00/5",
                     bus.IdEx_Valid_o, bus.IdEx_Ctrl_o, bus.IdEx_Imm_o);
        end
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 8'd0, 32'd0, 1'b0);
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        drive(5'd1, 5'd2, 5'd0, CTRL_LW, 32'h44, 1'b0);
        step();
        @(negedge clk);
        drive(5'd2, 5'd4, 5'd3, CTRL_ADD, 32'd0, 1'b0);
        #1;
        checks++;
        if (bus.Stall_o !== 1'b1) begin
            failures++;
            $display("FAIL ar_prestall stall=%b required 1", bus.Stall_o);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.IdEx_Valid_o !== 1'b0 || bus.IdEx_Ctrl_o !== 8'd0 || bus.IdEx_rt_o !== 5'd0 ||
            bus.IdEx_RsData_o !== 32'd0 || bus.IdEx_Imm_o !== 32'd0 || bus.StallCnt_o !== 32'd0) begin
            failures++;
            $display("FAIL ar_clear valid=%b ctrl=%h rt=%0d rsd=%h imm=%h cnt=%0d required all 0",
                     bus.IdEx_Valid_o, bus.IdEx_Ctrl_o, bus.IdEx_rt_o,
                     bus.IdEx_RsData_o, bus.IdEx_Imm_o, bus.StallCnt_o);
        end
        checks++;
        if (bus.Stall_o !== 1'b0 || bus.PcWrite_o !== 1'b1 || bus.IfIdWrite_o !== 1'b1) begin
            failures++;
            $display("FAIL ar_enables stall=%b pcw=%b ifidw=%b required 0/1/1",
                     bus.Stall_o, bus.PcWrite_o, bus.IfIdWrite_o);
        end
        #1;
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.IdEx_Valid_o !== 1'b1 || bus.IdEx_Ctrl_o !== CTRL_ADD || bus.IdEx_rs_o !== 5'd2) begin
            failures++;
            $display("FAIL ar_release valid=%b ctrl=%h rs=%0d required 1/86/2",
                     bus.IdEx_Valid_o, bus.IdEx_Ctrl_o, bus.IdEx_rs_o);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_back_to_back();
        logic [4:0] t_rs [3];
        logic [4:0] t_rt [3];
        logic [4:0] t_rd [3];
        logic [7:0] t_ct [3];
        logic       exp_stall [5];
        int         pc;
        int         stalls;
        // lw $2,0($1); lw $5,0($2); add $6,$5,$0
        t_rs = '{5'd1, 5'd2, 5'd5};
        t_rt = '{5'd2, 5'd5, 5'd0};
        t_rd = '{5'd0, 5'd0, 5'd6};
        t_ct = '{CTRL_LW, CTRL_LW, CTRL_ADD};
        exp_stall = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        pc = 0;
        stalls = 0;
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 8'd0, 32'd0, 1'b0);
        step();
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            if (pc < 3) drive(t_rs[pc], t_rt[pc], t_rd[pc], t_ct[pc], 32'd0, 1'b0);
            #1;
            checks++;
            if (bus.Stall_o !== exp_stall[cyc]) begin
                failures++;
                $display("FAIL b2b_stall cycle=%0d stall=%b required %b",
                         cyc, bus.Stall_o, exp_stall[cyc]);
            end
            if (bus.Stall_o === 1'b1) stalls++;
            else pc++;
            step();
        end
        checks++;
        if (pc !== 3 || stalls !== 2) begin
            failures++;
            $display("FAIL b2b_issue issued=%0d stalls=%0d required 3/2", pc, stalls);
        end
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 8'd0, 32'd0, 1'b0);
        $display("test_back_to_back done");
    endtask

    task automatic test_stall_cnt();
        logic [31:0] exp_cnt;
        pulse_reset();
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            drive(5'd1, 5'd2, 5'd0, CTRL_LW, 32'd0, 1'b0);
            step();
            @(negedge clk);
            drive(5'd2, 5'd4, 5'd3, CTRL_ADD, 32'd0, 1'b0);
            step();                     // stall edge, bubble loaded
            step();                     // held add enters EX
            @(negedge clk);
            drive(5'd0, 5'd0, 5'd0, 8'd0, 32'd0, 1'b0);
            step();
        end
`ifdef IDEX_STALL_CNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (bus.StallCnt_o !== exp_cnt) begin
            failures++;
            $display("FAIL stall_cnt cnt=%0d required %0d", bus.StallCnt_o, exp_cnt);
        end
        $display("test_stall_cnt done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 8'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        test_reset();
        test_passthrough();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_stall_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 clk_i  in  1  pipeline clock; all state updates on the rising edge.
REQ-002 rst_i  in  1  reset; asynchronous, active-low.
REQ-003 IfId_rs_i, IfId_rt_i, IfId_rd_i  in  5 each  register fields of the instruction currently in ID.
REQ-004 RsData_i, RtData_i, Imm_i  in  32 each  register-file read data and sign-extended immediate.
REQ-005 Ctrl_i  in  8  packed as {RegWrite, MemToReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}.
REQ-006 Flush_i  in  1  squash the instruction in ID (taken branch or jump).
REQ-007 IdEx_rs_o, IdEx_rt_o, IdEx_rd_o  out  5 each  registered register fields; rs and rt feed the forwarding unit.
REQ-008 IdEx_RsData_o, IdEx_RtData_o, IdEx_Imm_o  out  32 each  registered data fields.
REQ-009 IdEx_Ctrl_o  out  8  registered control bits, same packing as Ctrl_i.
REQ-010 IdEx_Valid_o  out  1  high when EX holds a real instruction rather than a bubble.
REQ-011 Stall_o, PcWrite_o, IfIdWrite_o  out  1 each  load-use hazard indication and upstream write enables.
REQ-012 StallCnt_o  out  32  stall-cycle counter (see Configuration).

Function
REQ-013 Hazard detection is combinational: Stall_o = IdEx_Ctrl_o.MemRead & IdEx_Valid_o & (IdEx_rt_o != 0) & ((IdEx_rt_o == IfId_rs_i) | (IdEx_rt_o == IfId_rt_i)) & ~Flush_i.
REQ-014 PcWrite_o = IfIdWrite_o = ~Stall_o.
REQ-015 On each clock with Stall_o or Flush_i high, the stage loads a bubble: IdEx_Ctrl_o = 0 and IdEx_Valid_o = 0; all other fields load from their inputs.
REQ-016 Otherwise, every field loads from its input and IdEx_Valid_o = 1.
REQ-017 Latency is one cycle from input to output; there is no bypass path from input to output.
REQ-018 A load-use stall lasts exactly one cycle, because the bubble clears IdEx_Ctrl_o.MemRead.
REQ-019 When Flush_i and a hazard occur together, the flush wins: Stall_o stays 0 and PcWrite_o stays 1, so the branch target is fetched.
REQ-020 A load whose target is $0 (IdEx_rt_o == 0) never stalls.
REQ-021 Back-to-back loads with a dependency produce one bubble per dependent pair and no extra cycles.

Reset
REQ-022 While rst_i is low, all registered outputs are forced to 0 (IdEx_Valid_o = 0, IdEx_Ctrl_o = 0, all fields 0, StallCnt_o = 0) asynchronously.
REQ-023 Because of REQ-022, Stall_o = 0 and PcWrite_o = IfIdWrite_o = 1 during reset.
REQ-024 Reset asserted mid-stall discards the pending bubble; the first edge after release loads normally.

Configuration
REQ-025 Macro IDEX_STALL_CNT_EN controls the stall-cycle counter.
- Defined: StallCnt_o increments by 1 on every clock edge with Stall_o high.
- Defined: the counter saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: StallCnt_o is tied to 0 and no counter flops are generated.
- The port list is identical in both builds.

Verification
REQ-026 Scenario: lw $2,0($1) then add $3,$2,$4 -> Stall_o = 1 for one cycle; PcWrite_o = 0 in that cycle; the next IdEx_Ctrl_o = 0 with IdEx_Valid_o = 0; the add enters EX one cycle later with IdEx_rs_o = 2.
REQ-027 Scenario: lw $0,0($1) then add $3,$0,$4 -> Stall_o never asserts; no bubble.
REQ-028 Scenario: lw $2 then a dependent add with Flush_i = 1 in the same cycle -> Stall_o = 0, PcWrite_o = 1, and the next IdEx_Valid_o = 0.
REQ-029 Scenario: rst_i driven low asynchronously between clock edges while a load is in EX -> all outputs become 0 immediately, without waiting for a clock edge.
REQ-030 Scenario: IDEX_STALL_CNT_EN defined, three separate load-use pairs -> StallCnt_o = 3; with the macro undefined -> StallCnt_o = 0.
REQ-031 Scenario: independent instructions with Ctrl_i = 8'hA5 and Imm_i = 32'hFFFF_FFF0 -> the following cycle shows IdEx_Ctrl_o = 8'hA5, IdEx_Imm_o = 32'hFFFF_FFF0, IdEx_Valid_o = 1.
